// File: rtl/fpu_issue_pkg.sv
// rtl/fpu_issue_pkg.sv - shared types for the fpu issue controller
// Request record layout is {op, a, b, tag}; its width depends on the tag width.
package fpu_issue_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_ACK  = 3'd2,
    WAIT_DONE = 3'd3,
    DELIVER   = 3'd4
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int DATA_W = 32;

  function automatic int req_w(input int tag_w);
    return 1 + 2 * DATA_W + tag_w;
  endfunction

endpackage

// File: rtl/fpu_issue_fifo.sv
// rtl/fpu_issue_fifo.sv - synchronous request FIFO with full/empty/count
// DEPTH must be a power of two so the pointers wrap naturally.
module fpu_issue_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// rtl/fpu_issue_ctrl.sv - queues add/sub requests and issues them to the fpu one at a time
// Optional watchdog recovery for a hung fpu is enabled by defining FPU_ISSUE_TIMEOUT_EN.
module fpu_issue_ctrl
  import fpu_issue_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_c,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             fpu_start,
  output logic             fpu_op,
  output logic [31:0]      fpu_a,
  output logic [31:0]      fpu_b,
  input  logic             fpu_ready,
  input  logic [31:0]      fpu_c,
  output logic             fpu_rst
);

  localparam int RW = req_w(TAG_W);

  state_t               state;
  logic [TAG_W-1:0]     tag_q;
  logic [RW-1:0]        head;
  logic                 full;
  logic                 empty;
  logic [$clog2(DEPTH):0] count;
  logic                 pop;
  logic                 wd_expire;
  logic                 err_q;
  logic                 wd_rst_q;
  logic                 unused_count;

  assign req_ready    = !full;
  assign pop          = (state == IDLE) && !empty && fpu_ready;
  assign rsp_err      = err_q;
  assign fpu_rst      = wd_rst_q;
  assign unused_count = ^count;

  fpu_issue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (RW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (req_valid),
    .push_data ({req_op, req_a, req_b, req_tag}),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

`ifdef FPU_ISSUE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] wd_cnt;

  assign wd_expire = (wd_cnt == CNT_W'(TIMEOUT - 1));

  // Counts every cycle spent waiting on the fpu; ISSUE is the cycle before WAIT_ACK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (state == ISSUE) begin
      wd_cnt <= '0;
    end else if ((state == WAIT_ACK || state == WAIT_DONE) && !wd_expire) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign wd_expire      = 1'b0;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      fpu_start <= 1'b0;
      fpu_op    <= OP_ADD;
      fpu_a     <= '0;
      fpu_b     <= '0;
      tag_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_c     <= '0;
      rsp_tag   <= '0;
      err_q     <= 1'b0;
      wd_rst_q  <= 1'b0;
    end else begin
      fpu_start <= 1'b0;
      wd_rst_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            {fpu_op, fpu_a, fpu_b, tag_q} <= head;
            fpu_start <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: state <= WAIT_ACK;
        WAIT_ACK: begin
          // ready is still high from before start; only its drop means the op was taken
          if (!fpu_ready) begin
            state <= WAIT_DONE;
          end else if (wd_expire) begin
            wd_rst_q  <= 1'b1;
            rsp_c     <= '0;
            rsp_tag   <= tag_q;
            err_q     <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= DELIVER;
          end
        end
        WAIT_DONE: begin
          if (fpu_ready) begin
            rsp_c     <= fpu_c;
            rsp_tag   <= tag_q;
            err_q     <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= DELIVER;
          end else if (wd_expire) begin
            wd_rst_q  <= 1'b1;
            rsp_c     <= '0;
            rsp_tag   <= tag_q;
            err_q     <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= DELIVER;
          end
        end
        DELIVER: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Initiator side of the fpu start/ready handshake: accepts add/sub requests (op, A, B, tag) on a valid/ready input port and queues them in a small FIFO.
- Issues queued requests to the fpu one at a time, captures C when the fpu signals completion, and returns {C, tag, err} on a valid/ready response port.
- Sits between the datapath/testbench driver and the fpu; one operation in flight, results returned in order.

Parameters:
DEPTH, 4, request FIFO entries (power of two, >=2)
TAG_W, 4, request/response tag width
TIMEOUT, 64, watchdog cycle limit per operation (used only with FPU_ISSUE_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid&req_ready
req_op  in  1  0=add, 1=sub
req_a  in  32  left operand
req_b  in  32  right operand
req_tag  in  TAG_W  request tag
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid&rsp_ready
rsp_c  out  32  result
rsp_tag  out  TAG_W  tag of the completed request
rsp_err  out  1  watchdog expired; rsp_c forced to 0
fpu_start  out  1  to fpu start
fpu_op  out  1  to fpu op
fpu_a  out  32  to fpu A
fpu_b  out  32  to fpu B
fpu_ready  in  1  from fpu ready
fpu_c  in  32  from fpu C
fpu_rst  out  1  recovery reset pulse; the top level ORs it with rst into fpu rst

Behaviour:
- Reset values: req_ready=1; rsp_valid=0; rsp_c=0; rsp_tag=0; rsp_err=0; fpu_start=0; fpu_op=0; fpu_a=0; fpu_b=0; fpu_rst=0; FIFO empty; state IDLE; counter 0.
- Reset mid-operation: all of the above; queued and in-flight requests are discarded. The fpu shares rst.
- FIFO:
  - req_ready = !full.
  - Push on req_valid&req_ready; pop only in IDLE.
  - Pointers of log2(DEPTH) bits wrap modulo DEPTH; occupancy count of log2(DEPTH)+1 bits.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - No bypass: a request pushed into an empty FIFO is popped no earlier than the next edge.
- FSM, all outputs registered:
  - IDLE: if the FIFO is non-empty and fpu_ready=1, pop the head into holding registers (fpu_op/fpu_a/fpu_b, tag); go to ISSUE.
  - ISSUE: fpu_start=1 for exactly this one cycle; go to WAIT_ACK.
  - WAIT_ACK: wait for fpu_ready=0 (the fpu drops ready the edge after it samples start); then go to WAIT_DONE.
  - WAIT_DONE: on fpu_ready=1, capture fpu_c into rsp_c and the tag into rsp_tag; set rsp_err=0 and rsp_valid=1; go to DELIVER.
  - DELIVER: hold all rsp_* until rsp_ready=1; then clear rsp_valid and go to IDLE.
- fpu_op/fpu_a/fpu_b are held stable from ISSUE until the next pop.
- fpu_ready=1 during ISSUE is never treated as completion.
- Latency, with FIFO empty, FSM idle and rsp_ready=1:
  - Request accepted at edge 0; popped at edge 1; fpu_start high during cycle 2.
  - rsp_valid rises on the edge after the cycle in which fpu_ready is observed back at 1.
- Throughput: one operation in flight. While DELIVER stalls, the FIFO keeps accepting until full.

Optional Feature:
FPU_ISSUE_TIMEOUT_EN
- Defined:
  - Counter cleared on entry to WAIT_ACK; increments each cycle in WAIT_ACK and WAIT_DONE.
  - If it reaches TIMEOUT-1 without completion: fpu_rst=1 for one cycle; rsp_c=0, rsp_tag=held tag, rsp_err=1, rsp_valid=1; go to DELIVER.
  - This recovers from an fpu whose normalization never terminates (e.g. exact-zero result).
  - The fpu returns ready=1 out of its reset, so the next IDLE can issue immediately.
- Undefined: no counter; fpu_rst and rsp_err are constant 0; the FSM waits in WAIT_* indefinitely.

Decomposition:
- Package fpu_issue_pkg:
  - State encoding IDLE, ISSUE, WAIT_ACK, WAIT_DONE, DELIVER (3 bits).
  - OP_ADD=0, OP_SUB=1.
  - Request record layout (1+32+32+TAG_W bits).
- Sub-module fpu_issue_fifo: a synchronous FIFO parameterized by DEPTH and width, with full/empty/count outputs. The FSM and watchdog stay in the top.

Test Plan:
- Add: req op=0, A=0x3F800000, B=0x40000000, tag=1, rsp_ready=1 -> exactly one fpu_start pulse; rsp_c=0x40400000, rsp_tag=1, rsp_err=0; rsp_valid high for one cycle.
- Sub: op=1, A=0x40400000, B=0x3F800000, tag=2 -> rsp_c=0x40000000, rsp_tag=2.
- Backpressure/ordering: rsp_ready=0; offer tags 0..7 back-to-back -> req_ready falls after 5 accepts (1 in flight + 4 queued); release rsp_ready -> tags return 0,1,2,3,4 in order; no fpu_start while DELIVER is stalled.
- Simultaneous push/pop: FIFO holding 2 entries, push in the same cycle as an IDLE pop -> count stays 2; no entry lost or duplicated.
- Timeout (macro defined, TIMEOUT=64): op=1, A=B=0x3F800000 -> fpu_rst pulses once 64 cycles after entry to WAIT_ACK; rsp_err=1, rsp_c=0; a following 1.0+2.0 request completes with 0x40400000.
- Reset mid-op: assert rst during WAIT_DONE with 3 queued -> all outputs at reset values; FIFO empty; no response is ever produced for the discarded tags.
